// File: rtl/hx8352_bus_driver.sv
// ============================================================================
// Module   : hx8352_bus_driver
// Purpose  : 16-bit 8080-style parallel bus master for the HX8352 LCD
//            controller: one write or read cycle per request, strobe timing
//            set by parameters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hx8352_bus_driver #(
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2,
    parameter int RD_LOW_CYCLES  = 8,
    parameter int RD_HIGH_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_step,
    input  logic        bus_read,
    input  logic        command_or_data,
    input  logic [15:0] data_to_write,
    output logic        bus_done,
    output logic        bus_busy,
    output logic [15:0] read_data,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic [15:0] lcd_db_out,
    output logic        lcd_db_oe,
    input  logic [15:0] lcd_db_in
);

    // Zero or negative cycle counts collapse to the shortest legal phase.
    localparam int c_WR_LOW  = (WR_LOW_CYCLES  < 1) ? 1 : WR_LOW_CYCLES;
    localparam int c_WR_HIGH = (WR_HIGH_CYCLES < 1) ? 1 : WR_HIGH_CYCLES;
    localparam int c_RD_LOW  = (RD_LOW_CYCLES  < 1) ? 1 : RD_LOW_CYCLES;
    localparam int c_RD_HIGH = (RD_HIGH_CYCLES < 1) ? 1 : RD_HIGH_CYCLES;

    localparam logic [15:0] c_WR_LOW_M1  = 16'(c_WR_LOW  - 1);
    localparam logic [15:0] c_WR_HIGH_M1 = 16'(c_WR_HIGH - 1);
    localparam logic [15:0] c_RD_LOW_M1  = 16'(c_RD_LOW  - 1);
    localparam logic [15:0] c_RD_HIGH_M1 = 16'(c_RD_HIGH - 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SETUP       = 3'd1,
        STROBE_LOW  = 3'd2,
        STROBE_HIGH = 3'd3,
        DONE        = 3'd4
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_is_read;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 16'd0;
            r_is_read  <= 1'b0;
            bus_done   <= 1'b0;
            bus_busy   <= 1'b0;
            read_data  <= 16'h0000;
            lcd_rs     <= 1'b0;
            lcd_wr_n   <= 1'b1;
            lcd_rd_n   <= 1'b1;
            lcd_db_out <= 16'h0000;
            lcd_db_oe  <= 1'b0;
        end else begin
            bus_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A write request takes priority over a simultaneous read.
                    if (bus_step || bus_read) begin
                        r_is_read <= ~bus_step;
                        lcd_rs    <= command_or_data;
                        bus_busy  <= 1'b1;
                        r_state   <= SETUP;
                        if (bus_step) begin
                            lcd_db_out <= data_to_write;
                            lcd_db_oe  <= 1'b1;
                        end else begin
                            lcd_db_oe  <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    r_state <= STROBE_LOW;
                    if (r_is_read) begin
                        lcd_rd_n <= 1'b0;
                        r_cnt    <= c_RD_LOW_M1;
                    end else begin
                        lcd_wr_n <= 1'b0;
                        r_cnt    <= c_WR_LOW_M1;
                    end
                end
                STROBE_LOW: begin
                    if (r_cnt == 16'd0) begin
                        lcd_wr_n <= 1'b1;
                        lcd_rd_n <= 1'b1;
                        r_state  <= STROBE_HIGH;
                        if (r_is_read) begin
                            read_data <= lcd_db_in;
                            r_cnt     <= c_RD_HIGH_M1;
                        end else begin
                            r_cnt     <= c_WR_HIGH_M1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                STROBE_HIGH: begin
                    if (r_cnt == 16'd0) begin
                        r_state   <= DONE;
                        bus_done  <= 1'b1;
                        lcd_db_oe <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                DONE: begin
                    r_state  <= IDLE;
                    bus_busy <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hx8352_bus_driver.sv
// ============================================================================
// Module   : tb_hx8352_bus_driver
// Purpose  : Self-checking bench for hx8352_bus_driver (default timing plus a
//            WR_LOW_CYCLES=0 instance).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hx8352_bus_driver;

    localparam int c_WRL = 2, c_WRH = 2, c_RDL = 8, c_RDH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_step = 1'b0, bus_read = 1'b0, command_or_data = 1'b0;
    logic [15:0] data_to_write = 16'h0000;
    logic        bus_done, bus_busy, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_db_oe;
    logic [15:0] read_data, lcd_db_out, lcd_db_in;
    logic [15:0] cur_dbin = 16'h0000;

    logic        step1 = 1'b0, zero1 = 1'b0;
    logic [15:0] zero16 = 16'h0000;
    logic        done1, busy1, rs1, wr_n1, rd_n1, oe1;
    logic [15:0] rdata1, dbo1;

    int tests = 0, failed = 0, cyc = 0;

    // The panel only drives its value while the read strobe is low.
    assign lcd_db_in = lcd_rd_n ? 16'hDEAD : cur_dbin;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hx8352_bus_driver dut (
        .clk(clk), .rst(rst), .bus_step(bus_step), .bus_read(bus_read),
        .command_or_data(command_or_data), .data_to_write(data_to_write),
        .bus_done(bus_done), .bus_busy(bus_busy), .read_data(read_data),
        .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n),
        .lcd_db_out(lcd_db_out), .lcd_db_oe(lcd_db_oe), .lcd_db_in(lcd_db_in)
    );

    hx8352_bus_driver #(.WR_LOW_CYCLES(0), .WR_HIGH_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .bus_step(step1), .bus_read(zero1),
        .command_or_data(zero1), .data_to_write(zero16),
        .bus_done(done1), .bus_busy(busy1), .read_data(rdata1),
        .lcd_rs(rs1), .lcd_wr_n(wr_n1), .lcd_rd_n(rd_n1),
        .lcd_db_out(dbo1), .lcd_db_oe(oe1), .lcd_db_in(zero16)
    );

    typedef struct {
        int          acc;
        logic        rd;
        logic        cd;
        logic [15:0] data;
        logic [15:0] dbin;
    } exp_t;

    typedef struct {
        logic        step;
        logic        rd;
        logic        cd;
        logic [15:0] data;
        logic [15:0] dbin;
    } vec_t;

    exp_t        sbq[$];
    logic [15:0] model_rdata = 16'h0000;
    int          wr_w = 0, rd_w = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: strobe-time checks plus completion checks on bus_done.
    always @(negedge clk) begin
        if (rst) begin
            wr_w = 0;
            rd_w = 0;
        end else begin
            if (!lcd_wr_n && !lcd_rd_n) check("both_strobes_low", 1, 0);
            if (!lcd_rd_n && lcd_db_oe) check("oe_during_read", 1, 0);
            if (!lcd_wr_n) begin
                wr_w++;
                if (sbq.size() == 0) check("unexpected_write_strobe", 1, 0);
                else begin
                    check("wr_db_out", lcd_db_out, sbq[0].data);
                    check("wr_rs", lcd_rs, sbq[0].cd);
                    check("wr_oe", lcd_db_oe, 1);
                    check("wr_busy", bus_busy, 1);
                end
            end
            if (!lcd_rd_n) begin
                rd_w++;
                if (sbq.size() == 0) check("unexpected_read_strobe", 1, 0);
                else check("rd_rs", lcd_rs, sbq[0].cd);
            end
            if (bus_done) begin
                if (sbq.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("done_oe", lcd_db_oe, 0);
                    if (e.rd) begin
                        model_rdata = e.dbin;
                        check("rd_latency", cyc - e.acc, 1 + c_RDL + c_RDH);
                        check("rd_low_width", rd_w, c_RDL);
                        check("rd_no_wr", wr_w, 0);
                    end else begin
                        check("wr_latency", cyc - e.acc, 1 + c_WRL + c_WRH);
                        check("wr_low_width", wr_w, c_WRL);
                        check("wr_no_rd", rd_w, 0);
                    end
                    check("read_data", read_data, model_rdata);
                end
                wr_w = 0;
                rd_w = 0;
            end
        end
    end

    task automatic push_exp(input int acc, input logic rd, input logic cd,
                            input logic [15:0] data, input logic [15:0] dbin);
        exp_t e;
        e.acc = acc; e.rd = rd; e.cd = cd; e.data = data; e.dbin = dbin;
        sbq.push_back(e);
    endtask

    // One-cycle request, then scramble the inputs to show they were latched.
    task automatic do_xfer(input logic step, input logic rd, input logic cd,
                           input logic [15:0] data, input logic [15:0] dbin);
        @(negedge clk);
        bus_step = step; bus_read = rd; command_or_data = cd;
        data_to_write = data; cur_dbin = dbin;
        @(posedge clk);
        #1;
        push_exp(cyc, ~step, cd, data, dbin);
        bus_step = 1'b0; bus_read = 1'b0;
        command_or_data = ~cd; data_to_write = ~data;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check(name, sbq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs[6];

    initial begin
        int acc, w, lat;
        logic seen;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0022, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0052};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 16'hABCD, 16'h0000};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h5A5A, 16'hFFFF};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h8001};

        // Reset: requests presented while rst is high must be ignored.
        bus_step = 1'b1; bus_read = 1'b1; data_to_write = 16'hFFFF;
        repeat (3) @(negedge clk);
        check("rst_wr_n", lcd_wr_n, 1);
        check("rst_rd_n", lcd_rd_n, 1);
        check("rst_rs", lcd_rs, 0);
        check("rst_db_out", lcd_db_out, 16'h0000);
        check("rst_oe", lcd_db_oe, 0);
        check("rst_done", bus_done, 0);
        check("rst_busy", bus_busy, 0);
        check("rst_read_data", read_data, 16'h0000);
        bus_step = 1'b0; bus_read = 1'b0; data_to_write = 16'h0000;
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_xfer(vecs[i].step, vecs[i].rd, vecs[i].cd, vecs[i].data, vecs[i].dbin);
            drain("vec_drain");
        end

        // Back-to-back writes with bus_step held: second accept 7 edges later.
        @(negedge clk);
        bus_step = 1'b1; command_or_data = 1'b1; data_to_write = 16'hF800;
        @(posedge clk);
        #1;
        acc = cyc;
        push_exp(acc, 1'b0, 1'b1, 16'hF800, 16'h0000);
        data_to_write = 16'h07E0;
        push_exp(acc + c_WRL + c_WRH + 3, 1'b0, 1'b1, 16'h07E0, 16'h0000);
        repeat (c_WRL + c_WRH + 3) @(posedge clk);
        #1;
        bus_step = 1'b0;
        drain("b2b_drain");

        // Reset during STROBE_LOW of a write aborts it without bus_done.
        @(negedge clk);
        bus_step = 1'b1; command_or_data = 1'b0; data_to_write = 16'h1111;
        @(posedge clk);
        #1;
        push_exp(cyc, 1'b0, 1'b0, 16'h1111, 16'h0000);
        bus_step = 1'b0;
        @(posedge clk);
        #2;
        check("abort_wr_low_before", lcd_wr_n, 0);
        rst = 1'b1;
        #1;
        check("abort_wr_n_async", lcd_wr_n, 1);
        check("abort_busy", bus_busy, 0);
        check("abort_done", bus_done, 0);
        sbq.delete();
        model_rdata = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        do_xfer(1'b1, 1'b0, 1'b1, 16'h2468, 16'h0000);
        drain("post_abort_drain");

        // WR_LOW_CYCLES=0 instance: one-cycle low strobe, latency 1+1+1.
        @(negedge clk);
        step1 = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        step1 = 1'b0;
        w = 0; lat = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (!wr_n1) w++;
            if (done1) begin
                seen = 1'b1;
                lat = cyc - acc;
            end
        end
        check("p0_done_seen", seen, 1);
        check("p0_wr_low_width", w, 1);
        check("p0_latency", lat, 3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
